// File: rtl/param_updown_counter_if.sv
// Control and status bundle of the modulus up/down counter.
// The master drives the controls; the counter (slave) returns count and status.
interface param_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] gray;
  logic             tc;
  logic             wrap;
  logic             at_limit;
  logic             load_err;

  modport master (
    output en, up, clr, load, load_val,
    input  count, gray, tc, wrap, at_limit, load_err
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, gray, tc, wrap, at_limit, load_err
  );
endinterface

// File: rtl/param_updown_counter.sv
// Modulus-MODULUS up/down counter with clear, clamped parallel load,
// wrap or saturate at the range ends, and Gray-coded / terminal-count status.
module param_updown_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 6,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  param_updown_counter_if.slave io_bus
);

  localparam logic [WIDTH:0]   C_MAX   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] C_MAX_W = C_MAX[WIDTH-1:0];

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_load_err;
  logic             r_at_limit;

  logic [WIDTH:0]   w_cur;
  logic [WIDTH:0]   w_ld;
  logic [WIDTH:0]   w_nxt;
  logic [WIDTH+1:0] w_step;
  logic             w_wrap_nxt;
  logic             w_lerr_nxt;
  logic             w_lim_nxt;

  // One enabled step in the given direction; returns {wrapped, next count}.
  // The extra bit keeps count+1 at the top of a full-range counter from overflowing.
  function automatic logic [WIDTH+1:0] f_step(input logic [WIDTH:0] cur, input logic dir);
    logic [WIDTH:0] nxt;
    logic           wr;
    nxt = cur;
    wr  = 1'b0;
    if (dir) begin
      if (cur >= C_MAX) begin
        if (SATURATE == 0) begin
          nxt = '0;
          wr  = 1'b1;
        end else begin
          nxt = C_MAX;
        end
      end else begin
        nxt = cur + 1'b1;
      end
    end else begin
      if (cur == '0) begin
        if (SATURATE == 0) begin
          nxt = C_MAX;
          wr  = 1'b1;
        end
      end else if (cur > C_MAX) begin
        nxt = C_MAX;
      end else begin
        nxt = cur - 1'b1;
      end
    end
    return {wr, nxt};
  endfunction

  assign w_cur  = {1'b0, r_count};
  assign w_ld   = {1'b0, io_bus.load_val};
  assign w_step = f_step(w_cur, io_bus.up);

  // Next state: clr beats load, load beats counting.
  always_comb begin
    w_nxt      = w_cur;
    w_wrap_nxt = 1'b0;
    w_lerr_nxt = 1'b0;
    if (io_bus.clr) begin
      w_nxt = '0;
    end else if (io_bus.load) begin
      if (w_ld > C_MAX) begin
        w_nxt      = C_MAX;
        w_lerr_nxt = 1'b1;
      end else begin
        w_nxt = w_ld;
      end
    end else if (io_bus.en) begin
      w_nxt      = w_step[WIDTH:0];
      w_wrap_nxt = w_step[WIDTH+1];
    end
    w_lim_nxt = (SATURATE != 0) && (io_bus.up ? (w_nxt == C_MAX) : (w_nxt == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      r_at_limit <= 1'b0;
    end else begin
      r_count    <= w_nxt[WIDTH-1:0];
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_lerr_nxt;
      r_at_limit <= w_lim_nxt;
    end
  end

  assign io_bus.count    = r_count;
  assign io_bus.gray     = r_count ^ (r_count >> 1);
  assign io_bus.tc       = io_bus.en & (io_bus.up ? (r_count == C_MAX_W) : (r_count == '0));
  assign io_bus.wrap     = r_wrap;
  assign io_bus.load_err = r_load_err;
  assign io_bus.at_limit = r_at_limit;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: three counters (wrap 3/6, saturate 3/6, wrap 2/2) share
// stimulus; directed vectors queue expected results, a monitor compares them.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, clr, load;
  logic [2:0] lv;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] cnt, gry, wr, tc, atl, lerr;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   gtab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  param_updown_counter_if #(.WIDTH(3)) b0 ();
  param_updown_counter_if #(.WIDTH(3)) b1 ();
  param_updown_counter_if #(.WIDTH(2)) b2 ();

  assign b0.en = en;  assign b0.up = up;  assign b0.clr = clr;  assign b0.load = load;  assign b0.load_val = lv;
  assign b1.en = en;  assign b1.up = up;  assign b1.clr = clr;  assign b1.load = load;  assign b1.load_val = lv;
  assign b2.en = en;  assign b2.up = up;  assign b2.clr = clr;  assign b2.load = load;  assign b2.load_val = lv[1:0];

  param_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u0 (.clk(clk), .rst(rst), .io_bus(b0));
  param_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .io_bus(b1));
  param_updown_counter #(.WIDTH(2), .MODULUS(2), .SATURATE(0)) u2 (.clk(clk), .rst(rst), .io_bus(b2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input int id, input int e, input int u, input int c, input int l, input int v,
                      input int cnt, input int wr, input int tc, input int atl, input int lerr,
                      input string nm);
    exp_t x;
    @(negedge clk);
    en = (e != 0); up = (u != 0); clr = (c != 0); load = (l != 0); lv = 3'(v);
    x.id = id; x.cnt = 8'(cnt); x.gry = 8'(gtab[cnt]); x.wr = 8'(wr);
    x.tc = 8'(tc); x.atl = 8'(atl); x.lerr = 8'(lerr); x.nm = nm;
    q.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0; clr = 1'b0; load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 8'(q.size()), 8'd0);
      q.delete();
    end
  endtask

  initial begin : monitor
    exp_t       x;
    logic [7:0] c, g, w, t, a, le;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        case (x.id)
          1: begin c = 8'(b1.count); g = 8'(b1.gray); w = 8'(b1.wrap); t = 8'(b1.tc); a = 8'(b1.at_limit); le = 8'(b1.load_err); end
          2: begin c = 8'(b2.count); g = 8'(b2.gray); w = 8'(b2.wrap); t = 8'(b2.tc); a = 8'(b2.at_limit); le = 8'(b2.load_err); end
          default: begin c = 8'(b0.count); g = 8'(b0.gray); w = 8'(b0.wrap); t = 8'(b0.tc); a = 8'(b0.at_limit); le = 8'(b0.load_err); end
        endcase
        chk({x.nm, ".count"}, c, x.cnt);
        chk({x.nm, ".gray"}, g, x.gry);
        chk({x.nm, ".wrap"}, w, x.wr);
        chk({x.nm, ".tc"}, t, x.tc);
        chk({x.nm, ".at_limit"}, a, x.atl);
        chk({x.nm, ".load_err"}, le, x.lerr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    int a_cnt [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int a_wr  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int a_tc  [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int d_cnt [8] = '{1, 2, 3, 4, 5, 5, 5, 5};
    int d_atl [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    rst = 1'b1; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; lv = 3'd0;

    // Reset state of all three instances
    #2;
    chk("rst.u0.count", 8'(b0.count), 8'd0);
    chk("rst.u1.count", 8'(b1.count), 8'd0);
    chk("rst.u2.count", 8'(b2.count), 8'd0);
    chk("rst.u0.wrap", 8'(b0.wrap), 8'd0);
    chk("rst.u0.load_err", 8'(b0.load_err), 8'd0);
    chk("rst.u1.at_limit", 8'(b1.at_limit), 8'd0);
    chk("rst.u0.tc_idle", 8'(b0.tc), 8'd0);
    en = 1'b1; up = 1'b0; #1;
    chk("rst.u0.tc_down", 8'(b0.tc), 8'd1);
    up = 1'b1; #1;
    chk("rst.u0.tc_up", 8'(b0.tc), 8'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Wrapping count-up through 5 -> 0
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "A.clr");
    for (int i = 0; i < 8; i++)
      step(0, 1, 1, 0, 0, 0, a_cnt[i], a_wr[i], a_tc[i], 0, 0, $sformatf("A.up%0d", i));

    // Load then count down through 0 -> 5
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "B.clr");
    step(0, 0, 1, 0, 1, 2, 2, 0, 0, 0, 0, "B.load2");
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "B.dn1");
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "B.dn2");
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "B.dn3");
    step(0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, "B.dn4");

    // Load clamping, load_err pulse, priorities, direction change
    step(0, 0, 1, 0, 1, 7, 5, 0, 0, 0, 1, "C.ld7");
    step(0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, "C.hold");
    step(0, 0, 1, 0, 1, 6, 5, 0, 0, 0, 1, "C.ld6");
    step(0, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0, "C.clr_ld7");
    step(0, 0, 1, 0, 1, 5, 5, 0, 0, 0, 0, "C.ld5");
    step(0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, "C.ld_over_en");
    step(0, 0, 1, 0, 1, 3, 3, 0, 0, 0, 0, "C.ld3");
    step(0, 1, 1, 0, 0, 0, 4, 0, 0, 0, 0, "C.up");
    step(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, "C.turn_dn");
    step(0, 1, 1, 0, 0, 0, 4, 0, 0, 0, 0, "C.turn_up");
    idle();
    drain();

    // Saturating instance
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "D.clr");
    for (int i = 0; i < 8; i++)
      step(1, 1, 1, 0, 0, 0, d_cnt[i], 0, (d_cnt[i] == 5) ? 1 : 0, d_atl[i], 0, $sformatf("D.up%0d", i));
    step(1, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, "D.dn");
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, "D.ld0");
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "D.hold0");
    step(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "D.up_again");
    step(1, 0, 1, 0, 1, 7, 5, 0, 0, 1, 1, "D.ld7");
    idle();
    drain();

    // Two-state counter: wrap every other cycle, then back-to-back wraps
    step(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "E.clr");
    step(2, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, "E.up1");
    step(2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "E.up2");
    step(2, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, "E.up3");
    step(2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "E.up4");
    step(2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, "E.bb1");
    step(2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "E.bb2");
    step(2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, "E.bb3");
    step(2, 0, 1, 0, 1, 3, 1, 0, 0, 0, 1, "E.ld3");
    idle();
    drain();

    // Asynchronous reset between edges, reset during a load, resume
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "F.clr");
    step(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "F.up1");
    step(0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, "F.up2");
    step(0, 1, 1, 0, 0, 0, 3, 0, 0, 0, 0, "F.up3");
    idle();
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("F.async.count", 8'(b0.count), 8'd0);
    chk("F.async.wrap", 8'(b0.wrap), 8'd0);
    @(negedge clk);
    load = 1'b1; lv = 3'd4; en = 1'b1; up = 1'b1;
    @(posedge clk);
    #1;
    chk("F.rst_load.count", 8'(b0.count), 8'd0);
    chk("F.rst_load.load_err", 8'(b0.load_err), 8'd0);
    @(negedge clk);
    load = 1'b0; en = 1'b0; rst = 1'b0;
    step(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "F.resume1");
    step(0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, "F.resume2");
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
